lc4_limb_alu: RTL and testbench
===============================

Name: lc4_limb_alu

Overview:
- Multi-cycle, parametrised successor to the single-cycle wide ECC ALU datapath.
- Processes a WORD_SIZE operand pair one LIMB-bit slice per clock, LSB first, rippling carry/borrow through a carry register, so 256+ bit field arithmetic needs no full-width adder.
- Sits between the register file read ports and writeback; valid/ready handshake on both input and output.

Parameters:
- WORD_SIZE, 256, operand/result width in bits; must be an integer multiple of LIMB.
- LIMB, 32, slice width processed per cycle; must be >= 2.
- NLIMB, WORD_SIZE/LIMB, derived localparam; number of processing cycles. Index counter width = clog2(NLIMB), minimum 1.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  request valid.
- o_ready  out  1  block can accept a request (high only in IDLE).
- i_op  in  3  000 ADD, 001 SUB, 010 NEG, 011 AND, 100 SRL1, 101 PASS, 110/111 illegal.
- i_cin  in  1  carry-in, used by ADD only.
- i_r1data  in  WORD_SIZE  operand A.
- i_r2data  in  WORD_SIZE  operand B.
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts result.
- o_result  out  WORD_SIZE  result.
- o_carry  out  1  carry-out / shifted-out bit.

Behaviour:
- Reset (async assert, sync release): state IDLE, o_valid=0, o_result=0, o_carry=0, carry reg=0, limb index=0. o_ready=1 after reset.
- Asserting reset mid-operation aborts it. No partial result is ever presented.
- FSM states: IDLE, RUN, DONE.
- IDLE: on i_valid && o_ready, latch A, B, op and cin, then go to RUN with idx=0.
- Initial carry register value on acceptance:
  - ADD: i_cin.
  - SUB, NEG: 1.
  - All other ops: 0.
- RUN: each edge computes result limb idx and writes it into o_result[idx*LIMB +: LIMB]. For ADD/SUB/NEG the slice carry-out is written to the carry register. idx increments; after writing idx==NLIMB-1, go to DONE.
- Per-limb operations:
  - ADD: a + b + c.
  - SUB: a + ~b + c.
  - NEG: ~a + c.
  - AND: a & b.
  - PASS: a.
  - SRL1: {next limb's bit0 (0 for top limb), a[LIMB-1:1]}.
- Latency: o_valid rises exactly NLIMB cycles after the accepting edge (8 for the defaults).
- o_carry in DONE:
  - ADD/SUB/NEG: final carry out. SUB carry=1 means no borrow.
  - SRL1: A[0].
  - AND/PASS: 0.
- DONE: o_valid=1. o_result and o_carry are held stable until i_ready=1, then go to IDLE. o_ready returns the following cycle, so there is no back-to-back acceptance.
- o_result upper limbs hold the previous value during RUN. Consumers must only sample when o_valid=1.
- Illegal op: still takes NLIMB cycles. o_result = 16'hDEAD zero-extended, o_carry=0.
- Inputs are ignored outside the IDLE acceptance cycle. Changes to i_op/i_r*data during RUN have no effect.
- Arithmetic wraps modulo 2^WORD_SIZE. No overflow flag.

Optional Feature:
- Macro: LC4_LIMB_ALU_FLAGS_EN.
- When defined, adds ports o_zero (1) and o_neg (1), both valid with o_valid:
  - o_zero = (o_result == 0). It is accumulated per limb via a sticky nonzero register, not a full-width compare.
  - o_neg = o_result[WORD_SIZE-1].
  - Both reset to 0.
- When not defined, the ports and logic are absent. Behaviour is otherwise identical.

Test Plan:
- Reset, then ADD A=2^256-1, B=1, cin=0 -> o_valid after 8 cycles, o_result=0, o_carry=1; with FLAGS_EN, o_zero=1.
- SUB A=5, B=7 -> o_result=2^256-2, o_carry=0 (borrow); with FLAGS_EN, o_neg=1. Then SUB A=7, B=5 -> 2, o_carry=1.
- NEG A=1 -> all ones, o_carry=0. NEG A=0 -> 0, o_carry=1.
- SRL1 A=2^32+1 (bit 32 set crosses a limb boundary) -> o_result=2^31, o_carry=1. AND A=0xF0F0, B=0xFF00 -> 0xF000.
- Hold i_ready=0 for 5 cycles in DONE -> o_result/o_valid stable, o_ready=0, and a new i_valid is ignored. Release i_ready -> o_ready=1 next cycle.
- Pull i_rst_n low at RUN idx=3 -> outputs 0 immediately. After release, a fresh ADD 1+1 -> 2 with the full 8-cycle latency. Illegal op 111 -> 0xDEAD, o_carry=0.

Source files
------------

// File: rtl/lc4_limb_alu_if.sv
// Request/response bundle between the register-file read ports, lc4_limb_alu and writeback.
// Defining LC4_LIMB_ALU_FLAGS_EN adds the o_zero/o_neg result flags.
interface lc4_limb_alu_if #(
   parameter int WORD_SIZE = 256
);
   logic                 i_valid;
   logic                 o_ready;
   logic [2:0]           i_op;
   logic                 i_cin;
   logic [WORD_SIZE-1:0] i_r1data;
   logic [WORD_SIZE-1:0] i_r2data;
   logic                 o_valid;
   logic                 i_ready;
   logic [WORD_SIZE-1:0] o_result;
   logic                 o_carry;
`ifdef LC4_LIMB_ALU_FLAGS_EN
   logic                 o_zero;
   logic                 o_neg;

   modport master (
      output i_valid, i_op, i_cin, i_r1data, i_r2data, i_ready,
      input  o_ready, o_valid, o_result, o_carry, o_zero, o_neg
   );

   modport slave (
      input  i_valid, i_op, i_cin, i_r1data, i_r2data, i_ready,
      output o_ready, o_valid, o_result, o_carry, o_zero, o_neg
   );
`else
   modport master (
      output i_valid, i_op, i_cin, i_r1data, i_r2data, i_ready,
      input  o_ready, o_valid, o_result, o_carry
   );

   modport slave (
      input  i_valid, i_op, i_cin, i_r1data, i_r2data, i_ready,
      output o_ready, o_valid, o_result, o_carry
   );
`endif
endinterface

// File: rtl/lc4_limb_alu.sv
// Limb-serial wide ALU: one LIMB-bit slice per clock, LSB first, carry rippled through a register.
// Optional result flags (o_zero/o_neg) are enabled with the LC4_LIMB_ALU_FLAGS_EN macro.
module lc4_limb_alu #(
   parameter int WORD_SIZE = 256,
   parameter int LIMB      = 32
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   lc4_limb_alu_if.slave bus
);
   localparam int NLIMB = WORD_SIZE / LIMB;
   localparam int IDXW  = (NLIMB > 1) ? $clog2(NLIMB) : 1;
   localparam logic [WORD_SIZE-1:0] ILLEGAL_RESULT = WORD_SIZE'(16'hDEAD);

   generate
      if (LIMB < 2 || (WORD_SIZE % LIMB) != 0) begin : g_bad_params
         $error("lc4_limb_alu: WORD_SIZE must be a multiple of LIMB and LIMB >= 2");
      end
   endgenerate

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_NEG  = 3'b010,
      OP_AND  = 3'b011,
      OP_SRL1 = 3'b100,
      OP_PASS = 3'b101
   } op_t;

   state_t               state_q, state_d;
   logic [IDXW-1:0]      idx_q, idx_d;
   logic                 carry_q, carry_d;
   logic [WORD_SIZE-1:0] result_q, result_d;
   logic                 cout_q, cout_d;
   logic [WORD_SIZE-1:0] a_q, a_d;
   logic [WORD_SIZE-1:0] b_q, b_d;
   op_t                  op_q, op_d;
   logic                 lsb_q, lsb_d;

   logic [LIMB-1:0]      a_l, b_l, limb;
   logic [LIMB:0]        sum;
   logic                 arith;
   logic                 srl_in;
   logic                 last;

   // Operands shift right one limb per cycle, so the active slice is always at the bottom.
   generate
      if (NLIMB > 1) begin : g_srl_multi
         assign srl_in = a_q[LIMB];
      end else begin : g_srl_single
         assign srl_in = 1'b0;
      end
   endgenerate

   assign a_l  = a_q[LIMB-1:0];
   assign b_l  = b_q[LIMB-1:0];
   assign last = (idx_q == IDXW'(NLIMB - 1));

   // NOTE: every signal written in an always_comb gets a default first, so no path infers a latch.
   always_comb begin
      sum   = '0;
      limb  = a_l;
      arith = 1'b0;
      case (op_q)
         OP_ADD:  begin sum = {1'b0, a_l} + {1'b0, b_l} + (LIMB+1)'(carry_q);  arith = 1'b1; end
         OP_SUB:  begin sum = {1'b0, a_l} + {1'b0, ~b_l} + (LIMB+1)'(carry_q); arith = 1'b1; end
         OP_NEG:  begin sum = {1'b0, ~a_l} + (LIMB+1)'(carry_q);               arith = 1'b1; end
         OP_AND:  limb = a_l & b_l;
         OP_SRL1: limb = {srl_in, a_l[LIMB-1:1]};
         default: limb = a_l;
      endcase
      if (arith) limb = sum[LIMB-1:0];
   end

`ifdef LC4_LIMB_ALU_FLAGS_EN
   logic nonzero_q, nonzero_d;
   logic zero_q, zero_d;
   logic neg_q, neg_d;
`endif

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      carry_d  = carry_q;
      result_d = result_q;
      cout_d   = cout_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      lsb_d    = lsb_q;
`ifdef LC4_LIMB_ALU_FLAGS_EN
      nonzero_d = nonzero_q;
      zero_d    = zero_q;
      neg_d     = neg_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.i_valid) begin
               state_d = S_RUN;
               idx_d   = '0;
               a_d     = bus.i_r1data;
               b_d     = bus.i_r2data;
               lsb_d   = bus.i_r1data[0];
`ifdef LC4_LIMB_ALU_FLAGS_EN
               nonzero_d = 1'b0;
`endif
               case (bus.i_op)
                  3'b000:  begin op_d = OP_ADD;  carry_d = bus.i_cin; end
                  3'b001:  begin op_d = OP_SUB;  carry_d = 1'b1; end
                  3'b010:  begin op_d = OP_NEG;  carry_d = 1'b1; end
                  3'b011:  begin op_d = OP_AND;  carry_d = 1'b0; end
                  3'b100:  begin op_d = OP_SRL1; carry_d = 1'b0; end
                  3'b101:  begin op_d = OP_PASS; carry_d = 1'b0; end
                  // Illegal ops stream the 0xDEAD marker through the PASS path for the same latency.
                  default: begin op_d = OP_PASS; carry_d = 1'b0; a_d = ILLEGAL_RESULT; end
               endcase
            end
         end
         S_RUN: begin
            for (int k = 0; k < NLIMB; k++) begin
               if (idx_q == IDXW'(k)) result_d[k*LIMB +: LIMB] = limb;
            end
            if (arith) carry_d = sum[LIMB];
            a_d   = a_q >> LIMB;
            b_d   = b_q >> LIMB;
            idx_d = idx_q + IDXW'(1);
`ifdef LC4_LIMB_ALU_FLAGS_EN
            nonzero_d = nonzero_q | (|limb);
`endif
            if (last) begin
               state_d = S_DONE;
               idx_d   = '0;
               if (arith)                cout_d = sum[LIMB];
               else if (op_q == OP_SRL1) cout_d = lsb_q;
               else                      cout_d = 1'b0;
`ifdef LC4_LIMB_ALU_FLAGS_EN
               zero_d = ~(nonzero_q | (|limb));
               neg_d  = limb[LIMB-1];
`endif
            end
         end
         S_DONE: begin
            if (bus.i_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state is updated with non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         carry_q  <= 1'b0;
         result_q <= '0;
         cout_q   <= 1'b0;
`ifdef LC4_LIMB_ALU_FLAGS_EN
         nonzero_q <= 1'b0;
         zero_q    <= 1'b0;
         neg_q     <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         carry_q  <= carry_d;
         result_q <= result_d;
         cout_q   <= cout_d;
`ifdef LC4_LIMB_ALU_FLAGS_EN
         nonzero_q <= nonzero_d;
         zero_q    <= zero_d;
         neg_q     <= neg_d;
`endif
      end
   end

   // NOTE: operand registers carry no reset; they are always loaded on acceptance before being read.
   always_ff @(posedge i_clk) begin
      a_q   <= a_d;
      b_q   <= b_d;
      op_q  <= op_d;
      lsb_q <= lsb_d;
   end

   assign bus.o_ready  = (state_q == S_IDLE);
   assign bus.o_valid  = (state_q == S_DONE);
   assign bus.o_result = result_q;
   assign bus.o_carry  = cout_q;
`ifdef LC4_LIMB_ALU_FLAGS_EN
   assign bus.o_zero   = zero_q;
   assign bus.o_neg    = neg_q;
`endif
endmodule

// File: tb/tb_lc4_limb_alu.sv
// Self-checking bench for lc4_limb_alu: full-width arithmetic model, directed corner cases, random traffic.
module tb_lc4_limb_alu;
   localparam int W  = 256;
   localparam int L  = 32;
   localparam int NL = W / L;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   lc4_limb_alu_if #(.WORD_SIZE(W)) bus ();

   lc4_limb_alu #(.WORD_SIZE(W), .LIMB(L)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Whole-word reference: bit W is the carry / shifted-out bit, bits W-1:0 the result.
   function automatic logic [W:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b, input logic cin);
      logic [W-1:0] dead;
      dead       = '0;
      dead[15:0] = 16'hDEAD;
      case (op)
         3'd0:    return {1'b0, a} + {1'b0, b} + (W+1)'(cin);
         3'd1:    return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
         3'd2:    return {1'b0, ~a} + (W+1)'(1);
         3'd3:    return {1'b0, a & b};
         3'd4:    return {a[0], 1'b0, a[W-1:1]};
         3'd5:    return {1'b0, a};
         default: return {1'b0, dead};
      endcase
   endfunction

   function automatic logic [W-1:0] rand_word();
      logic [W-1:0] w;
      for (int i = 0; i < W / 32; i++) w[i*32 +: 32] = $urandom;
      case ($urandom_range(0, 5))
         0:       w = '0;
         1:       w = '1;
         2:       w = W'($urandom_range(0, 3));
         default: ;
      endcase
      return w;
   endfunction

   // Compare process: follows each transaction from acceptance through DONE.
   int           mstate = 0;
   int           wait_cnt = 0;
   logic [W:0]   exp_full = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         mstate = 0;
      end else begin
         if (mstate == 3) begin
            check("ready_after_done", {{W{1'b0}}, bus.o_ready}, (W+1)'(1));
            check("valid_after_done", {{W{1'b0}}, bus.o_valid}, (W+1)'(0));
            mstate = 0;
         end
         if (mstate == 1) begin
            wait_cnt++;
            if (bus.o_valid) begin
               check("latency", (W+1)'(wait_cnt - 1), (W+1)'(NL));
               mstate = 2;
            end else if (wait_cnt > NL + 4) begin
               checks++;
               errors++;
               $display("FAIL run_timeout: no o_valid after %0d cycles, required %0d", wait_cnt, NL);
               mstate = 0;
            end else begin
               check("ready_low_run", {{W{1'b0}}, bus.o_ready}, (W+1)'(0));
            end
         end
         if (mstate == 2) begin
            if (!bus.o_valid) begin
               checks++;
               errors++;
               $display("FAIL valid_dropped: o_valid 0 before i_ready, required 1");
               mstate = 0;
            end else begin
               check("result", {1'b0, bus.o_result}, {1'b0, exp_full[W-1:0]});
               check("carry", {{W{1'b0}}, bus.o_carry}, {{W{1'b0}}, exp_full[W]});
               check("ready_low_done", {{W{1'b0}}, bus.o_ready}, (W+1)'(0));
`ifdef LC4_LIMB_ALU_FLAGS_EN
               check("zero_flag", {{W{1'b0}}, bus.o_zero}, {{W{1'b0}}, (exp_full[W-1:0] == '0)});
               check("neg_flag", {{W{1'b0}}, bus.o_neg}, {{W{1'b0}}, exp_full[W-1]});
`endif
               if (bus.i_ready) mstate = 3;
            end
         end
         if (mstate == 0 && bus.i_valid && bus.o_ready) begin
            exp_full = model(bus.i_op, bus.i_r1data, bus.i_r2data, bus.i_cin);
            wait_cnt = 0;
            mstate   = 1;
         end
      end
   end

   task automatic scramble_inputs();
      bus.i_op     = 3'($urandom);
      bus.i_cin    = 1'($urandom);
      bus.i_r1data = rand_word();
      bus.i_r2data = rand_word();
   endtask

   task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input int stall, input bit lit,
                       input logic [W:0] lit_exp, input string name);
      int n;
      n = 0;
      while (!bus.o_ready && n < 4 * NL) begin
         @(posedge clk); #1;
         n++;
      end
      bus.i_valid  = 1'b1;
      bus.i_op     = op;
      bus.i_r1data = a;
      bus.i_r2data = b;
      bus.i_cin    = cin;
      @(posedge clk); #1;
      bus.i_valid = 1'b0;
      scramble_inputs();
      n = 0;
      while (!bus.o_valid && n < NL + 4) begin
         @(posedge clk); #1;
         n++;
      end
      if (!bus.o_valid) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: o_valid still 0 after %0d cycles", name, n);
         return;
      end
      if (lit) begin
         check({name, "_res"}, {1'b0, bus.o_result}, {1'b0, lit_exp[W-1:0]});
         check({name, "_carry"}, {{W{1'b0}}, bus.o_carry}, {{W{1'b0}}, lit_exp[W]});
      end
      // Requests offered while the result waits must be ignored.
      repeat (stall) begin
         bus.i_valid = 1'b1;
         scramble_inputs();
         @(posedge clk); #1;
      end
      bus.i_valid = 1'b0;
      bus.i_ready = 1'b1;
      @(posedge clk); #1;
      bus.i_ready = 1'b0;
   endtask

   initial begin
      rst_n        = 1'b0;
      bus.i_valid  = 1'b0;
      bus.i_ready  = 1'b0;
      bus.i_op     = 3'd0;
      bus.i_cin    = 1'b0;
      bus.i_r1data = '0;
      bus.i_r2data = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", {{W{1'b0}}, bus.o_ready}, (W+1)'(1));
      check("rst_valid", {{W{1'b0}}, bus.o_valid}, (W+1)'(0));
      check("rst_result", {1'b0, bus.o_result}, (W+1)'(0));
      check("rst_carry", {{W{1'b0}}, bus.o_carry}, (W+1)'(0));
`ifdef LC4_LIMB_ALU_FLAGS_EN
      check("rst_zero", {{W{1'b0}}, bus.o_zero}, (W+1)'(0));
      check("rst_neg", {{W{1'b0}}, bus.o_neg}, (W+1)'(0));
`endif
      rst_n = 1'b1;
      @(posedge clk); #1;

      send(3'd0, '1, W'(1), 1'b0, 0, 1'b1, {1'b1, {W{1'b0}}}, "add_wrap");
      send(3'd1, W'(5), W'(7), 1'b0, 5, 1'b1, {1'b0, {(W-1){1'b1}}, 1'b0}, "sub_borrow");
      send(3'd1, W'(7), W'(5), 1'b0, 0, 1'b1, {1'b1, W'(2)}, "sub_noborrow");
      send(3'd2, W'(1), '0, 1'b0, 1, 1'b1, {1'b0, {W{1'b1}}}, "neg_one");
      send(3'd2, '0, '0, 1'b0, 0, 1'b1, {1'b1, W'(0)}, "neg_zero");
      send(3'd4, (W'(1) << 32) | W'(1), '0, 1'b0, 2, 1'b1, {1'b1, W'(1) << 31}, "srl1_cross");
      send(3'd3, W'(16'hF0F0), W'(16'hFF00), 1'b0, 0, 1'b1, {1'b0, W'(16'hF000)}, "and_mask");

      // Abort an ADD while the limb index is 3.
      bus.i_valid  = 1'b1;
      bus.i_op     = 3'd0;
      bus.i_r1data = rand_word();
      bus.i_r2data = rand_word();
      bus.i_cin    = 1'b1;
      @(posedge clk); #1;
      bus.i_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_result", {1'b0, bus.o_result}, (W+1)'(0));
      check("abort_carry", {{W{1'b0}}, bus.o_carry}, (W+1)'(0));
      check("abort_valid", {{W{1'b0}}, bus.o_valid}, (W+1)'(0));
      check("abort_ready", {{W{1'b0}}, bus.o_ready}, (W+1)'(1));
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      send(3'd0, W'(1), W'(1), 1'b0, 0, 1'b1, {1'b0, W'(2)}, "add_after_abort");
      send(3'd7, rand_word(), rand_word(), 1'b1, 0, 1'b1, {1'b0, W'(16'hDEAD)}, "illegal_op");
      send(3'd6, rand_word(), rand_word(), 1'b0, 0, 1'b1, {1'b0, W'(16'hDEAD)}, "illegal_op6");

      for (int i = 0; i < 60; i++) begin
         send(3'($urandom_range(0, 7)), rand_word(), rand_word(), 1'($urandom),
              int'($urandom_range(0, 3)), 1'b0, '0, "rand");
      end

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
